// File: rtl/display_scan_controller.sv
// display_scan_controller: double-dabble BCD conversion of Result plus anode scan with leading-zero blanking
module display_scan_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Result,
  input  logic              Result_valid,
  input  logic [3:0]        Letters,
  input  logic              disp_en,
  input  logic              blank_en,
  output logic [3:0]        Ones,
  output logic [3:0]        Tens,
  output logic [3:0]        Hundreds,
  output logic [1:0]        AN_SEL,
  output logic [3:0]        AN,
  output logic              busy
);
  localparam int CW = $clog2(REFRESH_DIV);
  typedef enum logic {IDLE, CONVERT} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] bin, pend_val;
  logic [11:0] bcd, adj, shifted;
  logic [2:0] cnt;
  logic pending, last, start, blank_h, blank_t, sel_blank;
  logic [CW-1:0] ref_cnt;
  logic unused_letters;
  assign unused_letters = ^Letters;
  assign last = cnt == 3'(DATA_W - 1);
  assign start = Result_valid || pending;
  assign busy = state == CONVERT;
  // add 3 to every BCD nibble >= 5, then shift the top binary bit in
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 3; i++)
      adj[i*4 +: 4] = bcd[i*4 +: 4] >= 4'd5 ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    shifted = {adj[10:0], bin[DATA_W-1]};
  end
  // conversion state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state: start on a strobe or pending value, stop after the last shift
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? CONVERT : IDLE) : (last ? IDLE : CONVERT);
  end
  // shift engine, pending capture and atomic digit update on the final shift
  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      pending <= 1'b0;
      pend_val <= '0;
      {Hundreds, Tens, Ones} <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        bin <= Result_valid ? Result : pend_val;
        bcd <= '0;
        cnt <= '0;
        pending <= 1'b0;
      end
    end else begin
      bin <= bin << 1;
      bcd <= shifted;
      cnt <= cnt + 3'd1;
      if (Result_valid) begin
        pending <= 1'b1;
        pend_val <= Result;
      end
      if (last) {Hundreds, Tens, Ones} <= shifted;
    end
  end
  // refresh divider stepping the digit select on every wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      AN_SEL <= 2'b00;
    end else if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      AN_SEL <= AN_SEL + 2'b01;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end
  // active-low anode for the selected digit unless disabled or blanked
  always_comb begin
    blank_h = blank_en && Hundreds == 4'd0;
    blank_t = blank_h && Tens == 4'd0;
    sel_blank = (AN_SEL == 2'b01 && blank_t) || (AN_SEL == 2'b10 && blank_h);
    AN = (!disp_en || sel_blank) ? 4'b1111 : ~(4'b0001 << AN_SEL);
  end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: randomized and directed checks against a decimal-arithmetic reference model
module tb_display_scan_controller;
  localparam int RD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] result = '0;
  logic result_valid = 1'b0;
  logic [3:0] letters = 4'hA;
  logic disp_en = 1'b1;
  logic blank_en = 1'b1;
  logic [3:0] ones, tens, hundreds, an;
  logic [1:0] an_sel;
  logic busy;
  int vectors = 0;
  int errors = 0;
  int m_left = 0, m_val = 0, m_pval = 0, m_cyc = 0;
  int m_h = 0, m_t = 0, m_o = 0;
  bit m_pend = 0;

  display_scan_controller #(.REFRESH_DIV(RD), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .Result(result), .Result_valid(result_valid),
    .Letters(letters), .disp_en(disp_en), .blank_en(blank_en),
    .Ones(ones), .Tens(tens), .Hundreds(hundreds),
    .AN_SEL(an_sel), .AN(an), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input int val, input bit de, input bit be);
    int sel;
    bit blank;
    logic [3:0] exp_an;
    rst = r;
    result_valid = v;
    result = 8'(val);
    disp_en = de;
    blank_en = be;
    letters = 4'($urandom_range(0, 15));
    @(posedge clk);
    if (r) begin
      m_left = 0; m_pend = 0; m_cyc = 0;
      m_h = 0; m_t = 0; m_o = 0;
    end else begin
      m_cyc++;
      if (m_left == 0) begin
        if (v || m_pend) begin
          m_val = v ? val : m_pval;
          m_left = 8;
          m_pend = 0;
        end
      end else begin
        if (v) begin
          m_pend = 1;
          m_pval = val;
        end
        m_left--;
        if (m_left == 0) begin
          m_h = m_val / 100;
          m_t = (m_val / 10) % 10;
          m_o = m_val % 10;
        end
      end
    end
    #1;
    sel = (m_cyc / RD) % 4;
    blank = be && ((sel == 2 && m_h == 0) || (sel == 1 && m_h == 0 && m_t == 0));
    exp_an = 4'b1111;
    if (de && !blank) exp_an[sel] = 1'b0;
    chk("busy", int'(busy), int'(m_left != 0));
    chk("ones", int'(ones), m_o);
    chk("tens", int'(tens), m_t);
    chk("hundreds", int'(hundreds), m_h);
    chk("an_sel", int'(an_sel), sel);
    chk("an", int'(an), int'(exp_an));
  endtask

  task automatic idle(input int n, input bit de, input bit be);
    for (int i = 0; i < n; i++) step(0, 0, 0, de, be);
  endtask

  initial begin
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    chk("reset_an", int'(an), 4'b1110);
    step(0, 1, 231, 1, 1);
    idle(10, 1, 1);
    chk("d231", int'({hundreds, tens, ones}), 12'h231);
    step(0, 1, 255, 1, 1);
    idle(10, 1, 1);
    step(0, 1, 0, 1, 1);
    idle(10, 1, 1);
    step(0, 1, 231, 1, 0);
    idle(20, 1, 0);
    idle(16, 0, 0);
    step(0, 1, 7, 1, 1);
    idle(20, 1, 1);
    step(0, 1, 40, 1, 1);
    idle(20, 1, 1);
    step(0, 1, 200, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 1, 45, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 1, 99, 1, 1);
    idle(3, 1, 1);
    chk("d200", int'({hundreds, tens, ones}), 12'h200);
    idle(9, 1, 1);
    chk("d099", int'({hundreds, tens, ones}), 12'h099);
    step(0, 1, 123, 1, 1);
    idle(3, 1, 1);
    step(1, 0, 0, 1, 1);
    idle(12, 1, 1);
    chk("rst_abort", int'({hundreds, tens, ones}), 12'h000);
    step(0, 1, 123, 1, 1);
    idle(10, 1, 1);
    chk("d123", int'({hundreds, tens, ones}), 12'h123);
    for (int i = 0; i < 3000; i++) begin
      int pick, val;
      pick = $urandom_range(0, 7);
      val = pick == 0 ? 0 : pick == 1 ? 7 : pick == 2 ? 40 : pick == 3 ? 255 : $urandom_range(0, 255);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, val,
           $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
